// File: rtl/pipeline_debug_unit.sv
// Run-control and state-dump unit between the UART byte link and the 5-stage pipeline.
// Gates the pipeline clock enable and, on halt, streams count, PC, registers and memory as bytes.
module pipeline_debug_unit #(
    parameter int          NUM_REGS   = 32,
    parameter int          MEM_WORDS  = 16,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [7:0]  CMD_RUN    = 8'h63,
    parameter logic [7:0]  CMD_STEP   = 8'h73,
    parameter logic [7:0]  CMD_HALT   = 8'h68
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] instr_if,
    input  logic [31:0] pc_if,
    output logic        pipe_en,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        debug_mode,
    output logic [31:0] debug_address,
    input  logic [31:0] mem_rdata,
    output logic [31:0] cycle_count
);

    localparam int WORD_TOTAL = NUM_REGS + MEM_WORDS + 2;
    localparam int WIDX_W     = $clog2(WORD_TOTAL);

    localparam logic [WIDX_W-1:0] FIRST_REG_WORD = WIDX_W'(2);
    localparam logic [WIDX_W-1:0] FIRST_MEM_WORD = WIDX_W'(NUM_REGS + 2);
    localparam logic [WIDX_W-1:0] LAST_WORD      = WIDX_W'(WORD_TOTAL - 1);

    typedef enum logic [2:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_D_LOAD,
        S_D_WAIT,
        S_D_SEND
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDX_W-1:0]   word_idx;
    logic [WIDX_W-1:0]   word_idx_next;
    logic [1:0]          byte_idx;
    logic [1:0]          byte_idx_next;
    logic [31:0]         shift_reg;
    logic [31:0]         shift_next;
    logic [31:0]         capture_word;
    logic                is_reg_word;
    logic                is_mem_word;
    logic                halt_request;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HALT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx    <= '0;
            byte_idx    <= '0;
            shift_reg   <= '0;
            cycle_count <= '0;
        end else begin
            word_idx  <= word_idx_next;
            byte_idx  <= byte_idx_next;
            shift_reg <= shift_next;
            if (pipe_en) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    // Debug read ports follow the word index; both rest at zero outside their word range.
    always_comb begin
        reg_sel       = '0;
        debug_address = '0;
        is_reg_word   = (word_idx >= FIRST_REG_WORD) && (word_idx < FIRST_MEM_WORD);
        is_mem_word   = (word_idx >= FIRST_MEM_WORD);
        if (is_reg_word) begin
            reg_sel = 5'(word_idx - FIRST_REG_WORD);
        end
        if (is_mem_word) begin
            debug_address = 32'(word_idx - FIRST_MEM_WORD);
        end
    end

    always_comb begin
        capture_word = reg_data;
        if (word_idx == '0) begin
            capture_word = cycle_count;
        end else if (word_idx == WIDX_W'(1)) begin
            capture_word = pc_if;
        end else if (is_mem_word) begin
            capture_word = mem_rdata;
        end
    end

    assign halt_request = (rx_valid && (rx_data == CMD_HALT)) || (instr_if == HALT_INSTR);

    // Outputs are decoded from the state register alone so the pipeline never sees a comb path from rx.
    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        byte_idx_next = byte_idx;
        shift_next    = shift_reg;
        pipe_en       = 1'b0;
        debug_mode    = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;

        case (state)
            S_HALT: begin
                if (rx_valid && (rx_data == CMD_RUN)) begin
                    state_next = S_RUN;
                end else if (rx_valid && (rx_data == CMD_STEP)) begin
                    state_next = S_STEP;
                end
            end

            S_RUN: begin
                pipe_en = 1'b1;
                if (halt_request) begin
                    state_next    = S_D_LOAD;
                    word_idx_next = '0;
                    byte_idx_next = '0;
                end
            end

            S_STEP: begin
                pipe_en       = 1'b1;
                state_next    = S_D_LOAD;
                word_idx_next = '0;
                byte_idx_next = '0;
            end

            S_D_LOAD: begin
                debug_mode = 1'b1;
                state_next = S_D_WAIT;
            end

            S_D_WAIT: begin
                debug_mode    = 1'b1;
                shift_next    = capture_word;
                byte_idx_next = '0;
                state_next    = S_D_SEND;
            end

            S_D_SEND: begin
                debug_mode = 1'b1;
                tx_valid   = 1'b1;
                tx_data    = shift_reg[31:24];
                if (tx_ready) begin
                    shift_next    = {shift_reg[23:0], 8'h00};
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (word_idx == LAST_WORD) begin
                            state_next    = S_HALT;
                            word_idx_next = '0;
                        end else begin
                            state_next    = S_D_LOAD;
                            word_idx_next = word_idx + WIDX_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_next = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Directed self-checking bench for pipeline_debug_unit: step, run-to-halt, throttled dump,
// reset mid-dump and ignored commands, with a combinational regfile and a 1-cycle data memory.
module tb_pipeline_debug_unit;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [7:0]  CMD_RUN    = 8'h63;
    localparam logic [7:0]  CMD_STEP   = 8'h73;
    localparam logic [7:0]  CMD_HALT   = 8'h68;
    localparam int          DUMP_BYTES = 200;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] instr_if;
    logic [31:0] pc_if;
    logic        pipe_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        debug_mode;
    logic [31:0] debug_address;
    logic [31:0] mem_rdata;
    logic [31:0] cycle_count;

    logic [31:0] reg_model [32];
    logic [31:0] mem_model [16];
    logic [7:0]  got [$];

    int n_checks;
    int n_fail;

    pipeline_debug_unit dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .instr_if      (instr_if),
        .pc_if         (pc_if),
        .pipe_en       (pipe_en),
        .reg_sel       (reg_sel),
        .reg_data      (reg_data),
        .debug_mode    (debug_mode),
        .debug_address (debug_address),
        .mem_rdata     (mem_rdata),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign reg_data = reg_model[reg_sel];

    always @(posedge clk) begin
        mem_rdata <= (debug_address < 32'd16) ? mem_model[debug_address[3:0]] : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] cnt, input logic [31:0] pc);
        int          w = k / 4;
        int          b = k % 4;
        logic [31:0] word;
        if (w == 0)       word = cnt;
        else if (w == 1)  word = pc;
        else if (w < 34)  word = reg_model[w - 2];
        else              word = mem_model[w - 34];
        return word[(31 - 8 * b) -: 8];
    endfunction

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    // Any pipe_en, tx_valid or debug_mode activity over the window counts as one failure.
    task automatic idle_check(input int n, input string tag);
        int busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (pipe_en || tx_valid || debug_mode) busy++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic run_window(input int max_cycles, input int nbytes, input bit throttle,
                              input int halt_run_cycle, input int inject_at,
                              output int pipe_cycles);
        logic [7:0] last_data = 8'h00;
        bit         last_pending = 1'b0;
        int         w;
        pipe_cycles = 0;
        got.delete();
        for (int cyc = 0; cyc < max_cycles && got.size() < nbytes; cyc++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            instr_if = NOP_INSTR;
            if (pipe_en) begin
                pipe_cycles++;
                if (pipe_cycles == halt_run_cycle) instr_if = HALT_INSTR;
            end
            tx_ready = throttle ? (cyc % 3 == 2) : 1'b1;
            if (tx_valid) begin
                if (last_pending) begin
                    check($sformatf("tx_data_stable_b%0d", got.size()), 32'(tx_data), 32'(last_data));
                end else if (got.size() % 4 == 0) begin
                    w = got.size() / 4;
                    check($sformatf("debug_mode_w%0d", w), 32'(debug_mode), 32'd1);
                    if (w >= 2 && w < 34) check($sformatf("reg_sel_w%0d", w), 32'(reg_sel), 32'(w - 2));
                    if (w >= 34) check($sformatf("debug_address_w%0d", w), debug_address, 32'(w - 34));
                end
                if (tx_ready) begin
                    got.push_back(tx_data);
                    last_pending = 1'b0;
                    if (got.size() == inject_at) begin
                        rx_valid = 1'b1;
                        rx_data  = CMD_STEP;
                    end
                end else begin
                    last_pending = 1'b1;
                    last_data    = tx_data;
                end
            end
        end
        check("dump_length", 32'(got.size()), 32'(nbytes));
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] cnt, input logic [31:0] pc);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(exp_byte(k, cnt, pc)));
        end
    endtask

    initial begin
        int pc_n;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        instr_if = NOP_INSTR;
        pc_if    = 32'h0000_1234;
        for (int i = 0; i < 32; i++) reg_model[i] = {8'(i), 8'hA5, 8'(i * 3 + 1), 8'h5A};
        for (int j = 0; j < 16; j++) mem_model[j] = 32'hDEAD_0000 + 32'(j * 257);

        $display("[TB] test 1: reset state");
        apply_reset(3);
        check("rst_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_debug_mode", 32'(debug_mode), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_debug_address", debug_address, 32'd0);
        idle_check(20, "rst_quiet_20");

        $display("[TB] test 2: single step dump");
        send_cmd(CMD_STEP);
        run_window(3000, DUMP_BYTES, 1'b0, 0, -1, pc_n);
        check("step_pipe_cycles", 32'(pc_n), 32'd1);
        check_bytes("step", 32'd1, 32'h0000_1234);
        idle_check(5, "step_after_quiet");
        check("step_cycle_count", cycle_count, 32'd1);

        $display("[TB] test 3: free run to halt instruction");
        apply_reset(2);
        pc_if = 32'h0000_0400;
        send_cmd(CMD_RUN);
        run_window(3000, DUMP_BYTES, 1'b0, 10, -1, pc_n);
        check("run_pipe_cycles", 32'(pc_n), 32'd10);
        check_bytes("run", 32'd10, 32'h0000_0400);
        check("run_cycle_count", cycle_count, 32'd10);

        $display("[TB] test 4: throttled dump");
        apply_reset(2);
        pc_if = 32'h8000_0001;
        send_cmd(CMD_STEP);
        run_window(5000, DUMP_BYTES, 1'b1, 0, -1, pc_n);
        check("thr_pipe_cycles", 32'(pc_n), 32'd1);
        check_bytes("thr", 32'd1, 32'h8000_0001);
        tx_ready = 1'b1;

        $display("[TB] test 5: reset mid-dump");
        apply_reset(2);
        pc_if = 32'h0000_00C8;
        send_cmd(CMD_STEP);
        run_window(3000, 57, 1'b0, 0, -1, pc_n);
        check_bytes("part", 32'd1, 32'h0000_00C8);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_debug_mode", 32'(debug_mode), 32'd0);
        check("mid_rst_cycle_count", cycle_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_check(4, "mid_rst_quiet");
        send_cmd(CMD_STEP);
        run_window(3000, DUMP_BYTES, 1'b0, 0, -1, pc_n);
        check_bytes("redo", 32'd1, 32'h0000_00C8);

        $display("[TB] test 6: ignored commands");
        apply_reset(2);
        send_cmd(8'h78);
        idle_check(6, "ignore_x");
        send_cmd(CMD_HALT);
        idle_check(6, "ignore_h_in_halt");
        check("ignore_cycle_count", cycle_count, 32'd0);
        pc_if = 32'h0000_0777;
        send_cmd(CMD_STEP);
        run_window(3000, DUMP_BYTES, 1'b0, 0, 40, pc_n);
        check("ignore_s_pipe_cycles", 32'(pc_n), 32'd1);
        check_bytes("ignore_s", 32'd1, 32'h0000_0777);
        idle_check(10, "ignore_s_after_quiet");
        check("ignore_s_cycle_count", cycle_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
